// File: rtl/banked_mem_arbiter_pkg.sv
// Shared constants and width helpers for the banked memory arbiter.
// Request-bit layout per core and the address-width derivation live here.
package mem_arb_pkg;

    localparam int RD_BIT = 0;
    localparam int WR_BIT = 1;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_width(input int num_banks, input int bank_depth);
        return $clog2(num_banks) + $clog2(bank_depth);
    endfunction

endpackage

// File: rtl/banked_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr,
// searching upward modulo N. One instance serves one bank.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid
);

    int            pos;
    logic [PW-1:0] idx;

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(ptr) + k) % N;
            idx = PW'(pos);
            if (!gnt_valid && req[idx]) begin
                gnt[idx]  = 1'b1;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/banked_mem_arbiter.sv
// Multi-bank shared memory front end: one round-robin arbiter and one
// single-port RAM per bank, with per-core registered read return.
module banked_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_CORES  = 16,
    parameter  int NUM_BANKS  = 16,
    parameter  int BANK_DEPTH = 256,
    parameter  int DATA_W     = 8,
    localparam int ADDR_W     = addr_width(NUM_BANKS, BANK_DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2*NUM_CORES-1:0]      enable,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wr_data,
    output logic [NUM_CORES-1:0]        grant,
    output logic [NUM_CORES*DATA_W-1:0] rd_data,
    output logic [NUM_CORES-1:0]        val
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int WORD_W = $clog2(BANK_DEPTH);
    localparam int CORE_W = idx_w(NUM_CORES);
    localparam logic [CORE_W-1:0] PTR_RST = CORE_W'(NUM_CORES - 1);

    logic [NUM_CORES-1:0] core_req;
    logic [NUM_CORES-1:0] core_wr;
    logic [BANK_W-1:0]    core_bank [NUM_CORES];
    logic [NUM_CORES-1:0] bank_req  [NUM_BANKS];
    logic [NUM_CORES-1:0] bank_gnt  [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_valid;
    logic [DATA_W-1:0]    bank_rd   [NUM_BANKS];

    genvar gi, gj;

    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            logic              val_q, val_d;
            logic [BANK_W-1:0] src_q, src_d;
            logic [DATA_W-1:0] hold_q, hold_d;
            logic              rd_grant;

            // Both bits set counts as a write.
            assign core_req[gi]  = enable[2*gi+RD_BIT] | enable[2*gi+WR_BIT];
            assign core_wr[gi]   = enable[2*gi+WR_BIT];
            assign core_bank[gi] = addr[gi*ADDR_W+WORD_W +: BANK_W];
            assign grant[gi]     = bank_gnt[core_bank[gi]][gi];
            assign rd_grant      = grant[gi] & ~core_wr[gi];

            // hold_q captures the returned word so rd_data persists after val.
            always_comb begin
                val_d  = rd_grant;
                src_d  = rd_grant ? core_bank[gi] : src_q;
                hold_d = val_q ? bank_rd[src_q] : hold_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    val_q  <= 1'b0;
                    src_q  <= '0;
                    hold_q <= '0;
                end else begin
                    val_q  <= val_d;
                    src_q  <= src_d;
                    hold_q <= hold_d;
                end
            end

            assign val[gi]                      = val_q;
            assign rd_data[gi*DATA_W +: DATA_W] = val_q ? bank_rd[src_q] : hold_q;
        end

        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [CORE_W-1:0] ptr_q, ptr_d, win;
            logic [WORD_W-1:0] w_word;
            logic [DATA_W-1:0] w_data;
            logic              w_wr;
            logic [DATA_W-1:0] mem [BANK_DEPTH];
            logic [DATA_W-1:0] rd_q;

            for (gj = 0; gj < NUM_CORES; gj++) begin : g_req
                assign bank_req[gi][gj] = core_req[gj] && (core_bank[gj] == BANK_W'(gi));
            end

            rr_arbiter #(
                .N(NUM_CORES)
            ) u_arb (
                .req       (bank_req[gi]),
                .ptr       (ptr_q),
                .gnt       (bank_gnt[gi]),
                .gnt_valid (bank_valid[gi])
            );

            always_comb begin
                win = '0;
                for (int c = 0; c < NUM_CORES; c++) begin
                    if (bank_gnt[gi][c]) win = CORE_W'(c);
                end
            end

            assign ptr_d = bank_valid[gi] ? win : ptr_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) ptr_q <= PTR_RST;
                else       ptr_q <= ptr_d;
            end

            assign w_word = addr[win*ADDR_W +: WORD_W];
            assign w_data = wr_data[win*DATA_W +: DATA_W];
            assign w_wr   = core_wr[win];

            // Single-port RAM with registered read; contents are never reset.
            always_ff @(posedge clk) begin
                if (bank_valid[gi]) begin
                    if (w_wr) mem[w_word] <= w_data;
                    else      rd_q        <= mem[w_word];
                end
            end

            assign bank_rd[gi] = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_banked_mem_arbiter.sv
// Directed self-checking bench for banked_mem_arbiter: default 16x16x256x8
// instance plus a small 4-core, 2-bank, 32-bit instance.
module tb_banked_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;

    logic [31:0]  enable;
    logic [191:0] addr;
    logic [127:0] wr_data;
    logic [15:0]  grant;
    logic [127:0] rd_data;
    logic [15:0]  val;

    logic [7:0]   enable2;
    logic [19:0]  addr2;
    logic [127:0] wr_data2;
    logic [3:0]   grant2;
    logic [127:0] rd_data2;
    logic [3:0]   val2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    banked_mem_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .addr    (addr),
        .wr_data (wr_data),
        .grant   (grant),
        .rd_data (rd_data),
        .val     (val)
    );

    banked_mem_arbiter #(
        .NUM_CORES  (4),
        .NUM_BANKS  (2),
        .BANK_DEPTH (16),
        .DATA_W     (32)
    ) dut2 (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable2),
        .addr    (addr2),
        .wr_data (wr_data2),
        .grant   (grant2),
        .rd_data (rd_data2),
        .val     (val2)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        enable  = '0;
        addr    = '0;
        wr_data = '0;
    endtask

    task automatic req(input int c, input bit rd, input bit wr,
                       input logic [11:0] a, input logic [7:0] d);
        enable[2*c]       = rd;
        enable[2*c+1]     = wr;
        addr[c*12 +: 12]  = a;
        wr_data[c*8 +: 8] = d;
    endtask

    initial begin
        logic [127:0] exp_rd;

        clr();
        enable2  = '0;
        addr2    = '0;
        wr_data2 = '0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_val", val, 16'h0);
        check("rst_rd", rd_data, 128'h0);
        check("rst_grant", grant, 16'h0);
        reset = 1'b0;

        // Write then read back from another core.
        req(0, 1'b0, 1'b1, 12'h012, 8'hA5);
        #1 check("t1_wr_grant", grant, 16'h0001);
        tick();
        check("t1_wr_val", val, 16'h0);
        clr();
        req(3, 1'b1, 1'b0, 12'h012, 8'h00);
        #1 check("t1_rd_grant", grant, 16'h0008);
        tick();
        check("t1_rd_val", val, 16'h0008);
        check("t1_rd_data", rd_data[31:24], 8'hA5);
        clr();
        tick();
        check("t1_val_drop", val, 16'h0);
        check("t1_rd_hold", rd_data[31:24], 8'hA5);

        // All cores contend for bank 5: strict rotation from core 0.
        for (int k = 0; k < 16; k++) req(k, 1'b1, 1'b0, {4'h5, 8'(k)}, 8'h00);
        for (int k = 0; k < 16; k++) begin
            #1 check("t2_rr_grant", grant, 16'(1) << k);
            tick();
            check("t2_rr_val", val, 16'(1) << k);
            enable[2*k] = 1'b0;
        end
        req(0, 1'b1, 1'b0, 12'h500, 8'h00);
        req(1, 1'b1, 1'b0, 12'h501, 8'h00);
        #1 check("t2_rereq_c0", grant, 16'h0001);
        tick();
        enable[0] = 1'b0;
        #1 check("t2_then_c1", grant, 16'h0002);
        tick();
        clr();

        // Every core hits its own bank: all served in one cycle.
        for (int i = 0; i < 16; i++) req(i, 1'b0, 1'b1, {4'(i), 8'h33}, 8'(i * 17));
        #1 check("t3_wr_grant", grant, 16'hFFFF);
        tick();
        check("t3_wr_val", val, 16'h0);
        for (int i = 0; i < 16; i++) req(i, 1'b1, 1'b0, {4'(i), 8'h33}, 8'h00);
        #1 check("t3_rd_grant", grant, 16'hFFFF);
        tick();
        check("t3_rd_val", val, 16'hFFFF);
        exp_rd = '0;
        for (int i = 0; i < 16; i++) exp_rd[i*8 +: 8] = 8'(i * 17);
        check("t3_rd_data", rd_data, exp_rd);
        clr();
        tick();
        check("t3_val_drop", val, 16'h0);

        // Both request bits set is a write.
        req(2, 1'b1, 1'b1, 12'h1FF, 8'h3C);
        #1 check("t4_both_grant", grant, 16'h0004);
        tick();
        check("t4_both_val", val, 16'h0);
        clr();
        req(2, 1'b1, 1'b0, 12'h1FF, 8'h00);
        #1 check("t4_rd_grant", grant, 16'h0004);
        tick();
        check("t4_rd_val", val, 16'h0004);
        check("t4_rd_data", rd_data[23:16], 8'h3C);
        clr();

        // Reset between grant and return, then arbitration restarts at core 0.
        req(7, 1'b1, 1'b0, 12'h012, 8'h00);
        #1 check("t5_rd_grant", grant, 16'h0080);
        tick();
        check("t5_pre_rst_val", val, 16'h0080);
        reset = 1'b1;
        #1 check("t5_rst_val", val, 16'h0);
        check("t5_rst_rd", rd_data, 128'h0);
        clr();
        tick();
        reset = 1'b0;
        req(4, 1'b1, 1'b0, 12'h020, 8'h00);
        req(9, 1'b1, 1'b0, 12'h030, 8'h00);
        #1 check("t5_c4_first", grant, 16'h0010);
        tick();
        enable[8] = 1'b0;
        #1 check("t5_c9_next", grant, 16'h0200);
        tick();
        clr();

        // Small configuration: 4 cores, 2 banks, 16 words, 32-bit data.
        enable2[3]       = 1'b1;
        addr2[9:5]       = 5'h1F;
        wr_data2[63:32]  = 32'hDEADBEEF;
        #1 check("t6_wr_grant", grant2, 4'h2);
        tick();
        check("t6_wr_val", val2, 4'h0);
        enable2          = '0;
        enable2[6]       = 1'b1;
        addr2[19:15]     = 5'h1F;
        #1 check("t6_rd_grant", grant2, 4'h8);
        tick();
        check("t6_rd_val", val2, 4'h8);
        check("t6_rd_data", rd_data2[127:96], 32'hDEADBEEF);
        enable2 = '0;
        tick();
        check("t6_val_drop", val2, 4'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
